// File: rtl/syn_tx_framer.sv
// -----------------------------------------------------------------------------
// syn_tx_framer
//
// Builds the transmit frame for the DA converter from a modulator sample
// stream. Each frame is:
//
//   PRE  : LENGTH_M_SEQ chips of the m-sequence preamble, MSB first.
//          Chip 1 is sent as all-zeros and chip 0 as all-ones, so the far
//          end recovers a chip as the inverted sample MSB.
//   DATA : LENGTH_SIGNAL = LENGTH_DATA + 4 sample slots. A slot takes the
//          modulator sample when valid is high; otherwise the slot carries
//          IDLE_LEVEL and tx_underrun pulses. The slot count never stretches.
//   GAP  : LENGTH_GAP samples of IDLE_LEVEL.
//
// A frame starts from IDLE on the first clock edge that sees modu_syn_valid.
// With valid held high, IDLE lasts one cycle between consecutive frames.
// syn_da_data and tx_underrun are registered and lag the FSM by one cycle.
//
// Ports
//   clk             in   single clock
//   arst_n          in   asynchronous active-low reset
//   modu_syn_valid  in   modulator has a payload sample
//   modu_syn_data   in   payload sample [DA_CVER_WIDTH]
//   modu_syn_ready  out  framer takes a sample this cycle (state == DATA)
//   syn_da_data     out  registered sample to the DA [DA_CVER_WIDTH]
//   tx_busy         out  high while a frame is in progress (state != IDLE)
//   tx_underrun     out  one-cycle pulse per DATA slot sent without valid,
//                        aligned with the IDLE_LEVEL sample it produced
// -----------------------------------------------------------------------------
module syn_tx_framer #(
    parameter int                         DA_CVER_WIDTH = 12,
    parameter int                         LENGTH_DATA   = 1024,
    parameter int                         LENGTH_M_SEQ  = 31,
    parameter logic [LENGTH_M_SEQ-1:0]    M_SEQ         = 31'b010_1000_1001_1100_0001_1001_0110_1111,
    parameter int                         LENGTH_GAP    = 16,
    parameter logic [DA_CVER_WIDTH-1:0]   IDLE_LEVEL    = 12'h800
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       modu_syn_valid,
    input  logic [DA_CVER_WIDTH-1:0]   modu_syn_data,
    output logic                       modu_syn_ready,
    output logic [DA_CVER_WIDTH-1:0]   syn_da_data,
    output logic                       tx_busy,
    output logic                       tx_underrun
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int LENGTH_SIGNAL = LENGTH_DATA + 4;

    // One shared counter times every phase, so it is sized for the longest.
    localparam int CNT_SPAN_A = (LENGTH_SIGNAL > LENGTH_M_SEQ) ? LENGTH_SIGNAL : LENGTH_M_SEQ;
    localparam int CNT_SPAN   = (CNT_SPAN_A > LENGTH_GAP) ? CNT_SPAN_A : LENGTH_GAP;
    localparam int CNT_MAX    = CNT_SPAN - 1;
    localparam int CNT_W      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(LENGTH_M_SEQ - 1);
    localparam logic [CNT_W-1:0] SIG_LAST = CNT_W'(LENGTH_SIGNAL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LENGTH_GAP - 1);

    localparam logic [DA_CVER_WIDTH-1:0] CHIP_ONE  = '0;
    localparam logic [DA_CVER_WIDTH-1:0] CHIP_ZERO = '1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_nxt;

    // The preamble is played out of a shift register that is reloaded with
    // M_SEQ whenever the FSM is outside PRE; its MSB is the current chip.
    logic [LENGTH_M_SEQ-1:0]     pre_sr;
    logic [LENGTH_M_SEQ-1:0]     pre_sr_nxt;

    logic [DA_CVER_WIDTH-1:0]    da_nxt;
    logic                        underrun_nxt;

    // -------------------------------------------------------------------------
    // Combinational handshake / status
    // -------------------------------------------------------------------------
    assign modu_syn_ready = (state == DATA);
    assign tx_busy        = (state != IDLE);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pre_sr      <= M_SEQ;
            syn_da_data <= IDLE_LEVEL;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pre_sr      <= pre_sr_nxt;
            syn_da_data <= da_nxt;
            tx_underrun <= underrun_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, counter and next-sample logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pre_sr_nxt   = M_SEQ;
        da_nxt       = IDLE_LEVEL;
        underrun_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (modu_syn_valid) begin
                    state_nxt = PRE;
                end
            end

            PRE: begin
                // Chip 1 -> all-zeros, chip 0 -> all-ones.
                da_nxt     = pre_sr[LENGTH_M_SEQ-1] ? CHIP_ONE : CHIP_ZERO;
                pre_sr_nxt = {pre_sr[LENGTH_M_SEQ-2:0], 1'b0};
                if (cnt == PRE_LAST) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DATA: begin
                // The slot is consumed whether or not a sample arrives, so the
                // frame length on the DA never depends on the modulator.
                if (modu_syn_valid && modu_syn_ready) begin
                    da_nxt = modu_syn_data;
                end else begin
                    underrun_nxt = 1'b1;
                end
                if (cnt == SIG_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_syn_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_syn_tx_framer
//
// Self-checking bench for syn_tx_framer. The reference model tracks only the
// position inside the frame as a plain integer and derives the expected DA
// sample, underrun pulse, ready and busy from the frame layout. A loopback
// receiver correlates the decoded chips against the m-sequence and compares
// the following payload against the samples actually sent.
// -----------------------------------------------------------------------------
module tb_syn_tx_framer;

    localparam int W     = 12;
    localparam int LD    = 1024;
    localparam int LM    = 31;
    localparam int LG    = 16;
    localparam int SIG   = LD + 4;
    localparam int FRAME = LM + SIG + LG;
    localparam logic [LM-1:0] MSEQ     = 31'b010_1000_1001_1100_0001_1001_0110_1111;
    localparam logic [W-1:0]  IDLE_LVL = 12'h800;

    logic          clk = 1'b0;
    logic          arst_n = 1'b1;
    logic          modu_syn_valid = 1'b0;
    logic [W-1:0]  modu_syn_data = '0;
    logic          modu_syn_ready;
    logic [W-1:0]  syn_da_data;
    logic          tx_busy;
    logic          tx_underrun;

    always #5 clk = ~clk;

    syn_tx_framer #(
        .DA_CVER_WIDTH (W),
        .LENGTH_DATA   (LD),
        .LENGTH_M_SEQ  (LM),
        .M_SEQ         (MSEQ),
        .LENGTH_GAP    (LG),
        .IDLE_LEVEL    (IDLE_LVL)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .modu_syn_valid (modu_syn_valid),
        .modu_syn_data  (modu_syn_data),
        .modu_syn_ready (modu_syn_ready),
        .syn_da_data    (syn_da_data),
        .tx_busy        (tx_busy),
        .tx_underrun    (tx_underrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: p = -1 idle, otherwise position 0..FRAME-1 in the frame.
    int           p        = -1;
    logic [W-1:0] exp_da   = IDLE_LVL;
    logic         exp_und  = 1'b0;
    logic [W-1:0] mod_data = '0;
    logic [W-1:0] sent_q[$];

    // Observations of the most recent cycle and window statistics.
    logic [W-1:0] obs_da;
    logic         obs_und, obs_ready, obs_busy;
    logic         prev_ready = 1'b0;
    int           cnt_ready, cnt_und, cnt_und_idle, cnt_busy_low, ready_rises;

    // Loopback receiver.
    bit           rx_en = 1'b0;
    bit           rx_cap = 1'b0;
    logic [LM-1:0] rx_sr = '0;
    int           rx_idx, rx_syncs, rx_cnt;

    task automatic clear_stats();
        cnt_ready    = 0;
        cnt_und      = 0;
        cnt_und_idle = 0;
        cnt_busy_low = 0;
        ready_rises  = 0;
    endtask

    task automatic model_step(input logic v);
        exp_und = 1'b0;
        if (p < 0) begin
            exp_da = IDLE_LVL;
            if (v) p = 0;
        end else if (p < LM) begin
            exp_da = MSEQ[LM-1-p] ? {W{1'b0}} : {W{1'b1}};
            p++;
        end else if (p < LM + SIG) begin
            if (v) begin
                exp_da = mod_data;
                sent_q.push_back(mod_data);
                mod_data++;
            end else begin
                exp_da  = IDLE_LVL;
                exp_und = 1'b1;
            end
            p++;
        end else begin
            exp_da = IDLE_LVL;
            p++;
            if (p == FRAME) p = -1;
        end
    endtask

    task automatic rx_step(input logic [W-1:0] s);
        logic [W-1:0] want;
        if (rx_cap) begin
            rx_cnt++;
            want = (sent_q.size() > 0) ? sent_q.pop_front() : {W{1'bx}};
            checks++;
            if (s !== want) begin
                errors++;
                $display("FAIL rx_payload idx=%0d got=%h want=%h", rx_idx, s, want);
            end
            rx_idx++;
            if (rx_idx == SIG) rx_cap = 1'b0;
        end else begin
            rx_sr = {rx_sr[LM-2:0], ~s[W-1]};
            if (rx_sr == MSEQ) begin
                rx_syncs++;
                rx_cap = 1'b1;
                rx_idx = 0;
            end
        end
    endtask

    // One clock cycle: observe and score at the falling edge, drive inputs,
    // then advance the model with the inputs the DUT saw at the rising edge.
    task automatic tick(input logic v);
        logic m_ready, m_busy;
        @(negedge clk);
        obs_da    = syn_da_data;
        obs_und   = tx_underrun;
        obs_ready = modu_syn_ready;
        obs_busy  = tx_busy;
        m_ready   = (p >= LM) && (p < LM + SIG);
        m_busy    = (p >= 0);
        checks++;
        if (obs_da !== exp_da) begin
            errors++;
            $display("FAIL da_sample p=%0d got=%h want=%h", p, obs_da, exp_da);
        end
        checks++;
        if (obs_und !== exp_und) begin
            errors++;
            $display("FAIL underrun p=%0d got=%b want=%b", p, obs_und, exp_und);
        end
        checks++;
        if (obs_ready !== m_ready) begin
            errors++;
            $display("FAIL ready p=%0d got=%b want=%b", p, obs_ready, m_ready);
        end
        checks++;
        if (obs_busy !== m_busy) begin
            errors++;
            $display("FAIL busy p=%0d got=%b want=%b", p, obs_busy, m_busy);
        end
        if (obs_ready === 1'b1) cnt_ready++;
        if (obs_ready === 1'b1 && prev_ready !== 1'b1) ready_rises++;
        prev_ready = obs_ready;
        if (obs_und === 1'b1) cnt_und++;
        if (obs_und === 1'b1 && obs_da === IDLE_LVL) cnt_und_idle++;
        if (obs_busy === 1'b0) cnt_busy_low++;
        if (rx_en) rx_step(obs_da);
        modu_syn_valid = v;
        modu_syn_data  = mod_data;
        @(posedge clk);
        model_step(v);
    endtask

    // Assert reset between clock edges, check outputs drop at once, hold it
    // over a few edges with valid high, then release at a falling edge.
    task automatic do_reset(input string tag);
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (syn_da_data !== IDLE_LVL) begin
            errors++;
            $display("FAIL %s_da got=%h want=%h", tag, syn_da_data, IDLE_LVL);
        end
        checks++;
        if ({modu_syn_ready, tx_busy, tx_underrun} !== 3'b000) begin
            errors++;
            $display("FAIL %s_flags got=%b want=000", tag, {modu_syn_ready, tx_busy, tx_underrun});
        end
        modu_syn_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_busy !== 1'b0 || syn_da_data !== IDLE_LVL) begin
            errors++;
            $display("FAIL %s_held busy=%b da=%h want busy=0 da=%h", tag, tx_busy, syn_da_data, IDLE_LVL);
        end
        modu_syn_valid = 1'b0;
        p       = -1;
        exp_da  = IDLE_LVL;
        exp_und = 1'b0;
        @(negedge clk);
        arst_n  = 1'b1;
    endtask

    // From IDLE with valid high: start the frame and decode the preamble.
    task automatic capture_preamble(input string tag);
        logic [LM-1:0] chips;
        logic [LM-1:0] want_pre;
        want_pre = 31'b0101000100111000001100101101111;
        chips    = '0;
        tick(1'b1);
        tick(1'b1);
        for (int i = 0; i < LM; i++) begin
            tick(1'b1);
            chips = {chips[LM-2:0], ~obs_da[W-1]};
        end
        checks++;
        if (chips !== want_pre) begin
            errors++;
            $display("FAIL %s_preamble got=%b want=%b", tag, chips, want_pre);
        end
    endtask

    task automatic align_frame_start();
        int n = 0;
        while (p != 0 && n < 2 * FRAME) begin
            tick(1'b1);
            n++;
        end
        checks++;
        if (p != 0) begin
            errors++;
            $display("FAIL align_timeout got_p=%0d want_p=0", p);
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b1;
        #3;
        do_reset("reset");
    endtask

    task automatic test_idle();
        clear_stats();
        repeat (60) tick(1'b0);
        checks++;
        if (cnt_busy_low != 60 || cnt_ready != 0) begin
            errors++;
            $display("FAIL idle_quiet busy_low=%0d ready=%0d want 60 and 0", cnt_busy_low, cnt_ready);
        end
    endtask

    task automatic test_frame();
        logic [W-1:0] want;
        mod_data = '0;
        clear_stats();
        capture_preamble("frame");
        for (int i = 0; i < SIG; i++) begin
            tick(1'b1);
            want = W'(i);
            checks++;
            if (obs_da !== want) begin
                errors++;
                $display("FAIL ramp idx=%0d got=%h want=%h", i, obs_da, want);
            end
        end
        for (int i = 0; i < LG; i++) begin
            tick(1'b1);
            checks++;
            if (obs_da !== 12'h800 || obs_und !== 1'b0) begin
                errors++;
                $display("FAIL gap idx=%0d got=%h und=%b want=800 und=0", i, obs_da, obs_und);
            end
        end
        checks++;
        if (cnt_und != 0) begin
            errors++;
            $display("FAIL frame_underruns got=%0d want=0", cnt_und);
        end
    endtask

    task automatic test_back_to_back();
        align_frame_start();
        for (int f = 0; f < 2; f++) begin
            clear_stats();
            repeat (FRAME + 1) tick(1'b1);
            checks++;
            if (cnt_ready != SIG || ready_rises != 1) begin
                errors++;
                $display("FAIL b2b_ready count=%0d rises=%0d want %0d and 1", cnt_ready, ready_rises, SIG);
            end
            checks++;
            if (cnt_busy_low != 1 || cnt_und != 0) begin
                errors++;
                $display("FAIL b2b_idle busy_low=%0d und=%0d want 1 and 0", cnt_busy_low, cnt_und);
            end
        end
    endtask

    task automatic test_underrun();
        align_frame_start();
        clear_stats();
        for (int i = 0; i < FRAME + 1; i++) begin
            tick((p >= LM + 100 && p < LM + 105) ? 1'b0 : 1'b1);
        end
        checks++;
        if (cnt_und != 5 || cnt_und_idle != 5) begin
            errors++;
            $display("FAIL underrun_count got=%0d at_idle=%0d want 5", cnt_und, cnt_und_idle);
        end
        checks++;
        if (cnt_ready != SIG) begin
            errors++;
            $display("FAIL underrun_data_len got=%0d want=%0d", cnt_ready, SIG);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (p != LM + 500 && n < 3 * FRAME) begin
            tick(1'b1);
            n++;
        end
        checks++;
        if (p != LM + 500) begin
            errors++;
            $display("FAIL reset_mid_reach got_p=%0d want_p=%0d", p, LM + 500);
        end
        do_reset("reset_mid");
        capture_preamble("restart");
        repeat (40) tick(1'b1);
    endtask

    task automatic test_loopback();
        do_reset("loop_reset");
        mod_data = '0;
        sent_q.delete();
        rx_sr    = '0;
        rx_cap   = 1'b0;
        rx_syncs = 0;
        rx_cnt   = 0;
        rx_en    = 1'b1;
        repeat (2 * (FRAME + 1) + 5) tick(1'b1);
        rx_en    = 1'b0;
        checks++;
        if (rx_syncs != 2) begin
            errors++;
            $display("FAIL loop_syncs got=%0d want=2", rx_syncs);
        end
        checks++;
        if (rx_cnt != 2 * SIG) begin
            errors++;
            $display("FAIL loop_samples got=%0d want=%0d", rx_cnt, 2 * SIG);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_back_to_back();
        test_underrun();
        test_random();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
